jtag_uart_arbiter: RTL
======================

Name: jtag_uart_arbiter

Overview:
- Owns the single Avalon port of the JTAG-UART core and shares it between two requesters.
- RX requester: continuous polling of the DATA register, delivering received bytes downstream to the command decoder.
- TX requester: bytes queued from the design, such as status and acknowledge replies, written back to the host.
- Sequences register accesses with an FSM, honours WAIT, tracks host write space, and enforces bounded-burst fairness between RX and TX.

Parameters:
- TX_FIFO_AW, 3, log2 of TX FIFO depth (depth = 8).
- RX_BURST, 4, maximum consecutive valid RX reads before TX gets a turn (1..15).
- TX_BURST, 2, maximum consecutive TX writes per turn (1..15).

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- oJTAG_SLAVE_ADDR  out  1  0 = DATA register, 1 = CONTROL register.
- oJTAG_SLAVE_RDREQ  out  1  Avalon read.
- iJTAG_SLAVE_RDDATA  in  32  Avalon read data.
- oJTAG_SLAVE_WRREQ  out  1  Avalon write.
- oJTAG_SLAVE_WRDATA  out  32  Avalon write data.
- iJTAG_SLAVE_WAIT  in  1  Avalon waitrequest.
- oRX_DATA  out  8  received byte.
- oRX_VALID  out  1  one-cycle strobe qualifying oRX_DATA.
- iTX_DATA  in  8  byte to transmit.
- iTX_VALID  in  1  push request.
- oTX_READY  out  1  TX FIFO not full.
- oTX_EMPTY  out  1  TX FIFO empty.

Behaviour:
- Single clock iCLK; reset iRST_N is asynchronous, active-low.
- Reset values:
  - all outputs 0 except oTX_EMPTY = 1;
  - FSM in ST_IDLE, turn = RX;
  - wspace_cnt = 0, burst counters = 0, FIFO empty.
- Reset mid-transaction abandons the access immediately and deasserts RDREQ/WRREQ.
- Avalon rule:
  - the request (address, read or write, and write data) is held stable while iJTAG_SLAVE_WAIT = 1;
  - the access completes in the first cycle with WAIT = 0, and read data is sampled in that cycle;
  - RDREQ and WRREQ are never asserted together.
- FSM states: ST_IDLE, ST_RD_DATA, ST_RD_CTRL, ST_WR_DATA. Every access returns to ST_IDLE, so there is exactly one idle cycle between accesses.
- ST_IDLE:
  - turn = TX and FIFO non-empty: go to ST_RD_CTRL if wspace_cnt == 0, else ST_WR_DATA.
  - Otherwise: go to ST_RD_DATA and set turn = RX.
- ST_RD_DATA (ADDR = 0, RDREQ = 1). On completion:
  - RDDATA[15] = 1: register oRX_DATA = RDDATA[7:0] and pulse oRX_VALID for the next cycle; increment rx_cnt.
  - When rx_cnt reaches RX_BURST, or RDDATA[15] = 0: set turn = TX and rx_cnt = 0.
- ST_RD_CTRL (ADDR = 1, RDREQ = 1). On completion:
  - wspace_cnt = RDDATA[31:16];
  - if that value is 0, set turn = RX (prevents control-poll starvation of RX).
- ST_WR_DATA (ADDR = 0, WRREQ = 1, WRDATA = {24'd0, FIFO head}). On completion:
  - pop the FIFO, decrement wspace_cnt, increment tx_cnt;
  - if tx_cnt reaches TX_BURST, or the FIFO becomes empty, or wspace_cnt becomes 0: set turn = RX and tx_cnt = 0.
- TX FIFO:
  - a push occurs when iTX_VALID & oTX_READY;
  - iTX_VALID while full is ignored (byte dropped, no error);
  - simultaneous push and pop are legal and leave the level unchanged;
  - pointers wrap modulo depth;
  - oTX_READY and oTX_EMPTY are registered-state-derived, with no combinational path from iTX_VALID.
- wspace_cnt is 16 bits and never underflows (a write is only issued when it is > 0).
- Latency: host byte available in RDDATA to oRX_VALID is 1 cycle after the completing cycle.

Optional Feature:
- Macro JTAG_UART_ARBITER_ECHO_EN.
- When defined:
  - every valid RX byte is also pushed into the TX FIFO in the same cycle oRX_VALID asserts (loopback echo for host terminal debugging);
  - the echo push has priority over iTX_VALID, and oTX_READY is forced to 0 in that cycle;
  - an echo arriving with the FIFO full is dropped.
- When undefined: no echo path; the TX FIFO is fed only by iTX_VALID.

Test Plan:
- Reset then release, WAIT = 0, RDDATA = 0 → all outputs 0, oTX_EMPTY = 1; RDREQ = 1 with ADDR = 0 on the 2nd cycle after release; RD_DATA/IDLE repeats while TX is empty.
- RD_DATA with WAIT held 3 cycles, then RDDATA = 0x0001_8041 → RDREQ and ADDR stable throughout; oRX_DATA = 0x41 with a single-cycle oRX_VALID.
- Push 0x55; first CTRL read returns 0x0000_0000 → no write and the next access is RD_DATA; later CTRL read returns 0x0040_0000 → one write, WRDATA = 0x0000_0055, ADDR = 0, then oTX_EMPTY = 1.
- RX always valid, 5 bytes queued, wspace = 64, RX_BURST = 4, TX_BURST = 2 → access order 4×RD_DATA, RD_CTRL, 2×WR, 4×RD_DATA, 2×WR, 4×RD_DATA, 1×WR.
- CTRL returns wspace 0 forever, push 9 bytes back-to-back → oTX_READY falls after the 8th push; 9th byte dropped; WRREQ never asserted.
- With ECHO_EN, RX byte 0x7A, wspace 16 → oRX_VALID pulses, and a later write carries WRDATA = 0x0000_007A. Without the macro → no write.

Source files
------------

// File: rtl/jtag_uart_arbiter_if.sv
// jtag_uart_arbiter_if: bundles the JTAG-UART Avalon port and the RX/TX byte
// streams that the arbiter multiplexes onto it.
//   master : arbiter side (drives Avalon request, RX strobe, TX flow control)
//   slave  : peer side (Avalon slave + stream endpoints)
//   oJTAG_SLAVE_ADDR/RDREQ/WRREQ/WRDATA, iJTAG_SLAVE_RDDATA/WAIT : Avalon port
//   oRX_DATA/oRX_VALID : received byte stream
//   iTX_DATA/iTX_VALID, oTX_READY/oTX_EMPTY : transmit byte queue
interface jtag_uart_arbiter_if;
   logic        oJTAG_SLAVE_ADDR;
   logic        oJTAG_SLAVE_RDREQ;
   logic [31:0] iJTAG_SLAVE_RDDATA;
   logic        oJTAG_SLAVE_WRREQ;
   logic [31:0] oJTAG_SLAVE_WRDATA;
   logic        iJTAG_SLAVE_WAIT;
   logic [7:0]  oRX_DATA;
   logic        oRX_VALID;
   logic [7:0]  iTX_DATA;
   logic        iTX_VALID;
   logic        oTX_READY;
   logic        oTX_EMPTY;

   modport master (
      output oJTAG_SLAVE_ADDR, oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ, oJTAG_SLAVE_WRDATA,
      output oRX_DATA, oRX_VALID, oTX_READY, oTX_EMPTY,
      input  iJTAG_SLAVE_RDDATA, iJTAG_SLAVE_WAIT, iTX_DATA, iTX_VALID
   );

   modport slave (
      input  oJTAG_SLAVE_ADDR, oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ, oJTAG_SLAVE_WRDATA,
      input  oRX_DATA, oRX_VALID, oTX_READY, oTX_EMPTY,
      output iJTAG_SLAVE_RDDATA, iJTAG_SLAVE_WAIT, iTX_DATA, iTX_VALID
   );
endinterface

// File: rtl/jtag_uart_arbiter.sv
// jtag_uart_arbiter: shares the single JTAG-UART Avalon port between an RX
// poller (DATA register reads) and a TX queue (DATA register writes), with
// host write-space tracking through CONTROL reads and bounded-burst fairness.
//   iCLK   : system clock
//   iRST_N : asynchronous active-low reset
//   bus    : jtag_uart_arbiter_if.master (Avalon port + RX/TX byte streams)
// Optional build macro JTAG_UART_ARBITER_ECHO_EN: loop every valid RX byte
// back into the TX FIFO (host terminal echo).
module jtag_uart_arbiter #(
   parameter int unsigned TX_FIFO_AW = 3,
   parameter int unsigned RX_BURST   = 4,
   parameter int unsigned TX_BURST   = 2
) (
   input logic                 iCLK,
   input logic                 iRST_N,
   jtag_uart_arbiter_if.master bus
);
   localparam int unsigned DEPTH = 1 << TX_FIFO_AW;
   localparam int unsigned LW    = TX_FIFO_AW + 1;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned WS_W  = 16;

   typedef enum logic [1:0] {ST_IDLE, ST_RD_DATA, ST_RD_CTRL, ST_WR_DATA} state_t;
   typedef enum logic {TURN_RX, TURN_TX} turn_t;

   state_t                state, stateNxt;
   turn_t                 turn, turnNxt;
   logic [CNT_W-1:0]      rxCnt, rxCntNxt, txCnt, txCntNxt;
   logic [WS_W-1:0]       wspaceCnt, wspaceCntNxt;
   logic [7:0]            fifoMem [DEPTH];
   logic [TX_FIFO_AW-1:0] wrPtr, rdPtr;
   logic [LW-1:0]         level, levelNxt;
   logic                  push, pop, rxLoad, readyNxt, done;
   logic [7:0]            pushData;
   logic [31:0]           rdData;
   logic [6:0]            unusedRdBits;

   assign rdData       = bus.iJTAG_SLAVE_RDDATA;
   assign unusedRdBits = rdData[14:8];
   assign done         = !bus.iJTAG_SLAVE_WAIT;

   // FIFO push source; echo owns the write port in the cycle oRX_VALID is high
`ifdef JTAG_UART_ARBITER_ECHO_EN
   assign push     = (bus.oRX_VALID && (level != LW'(DEPTH))) ||
                     (bus.iTX_VALID && bus.oTX_READY);
   assign pushData = bus.oRX_VALID ? bus.oRX_DATA : bus.iTX_DATA;
   assign readyNxt = (levelNxt != LW'(DEPTH)) && !rxLoad;
`else
   assign push     = bus.iTX_VALID && bus.oTX_READY;
   assign pushData = bus.iTX_DATA;
   assign readyNxt = (levelNxt != LW'(DEPTH));
`endif

   assign levelNxt = level + LW'(push) - LW'(pop);

   // Access sequencing and fairness bookkeeping
   always_comb begin
      stateNxt     = state;
      turnNxt      = turn;
      rxCntNxt     = rxCnt;
      txCntNxt     = txCnt;
      wspaceCntNxt = wspaceCnt;
      pop          = 1'b0;
      rxLoad       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (turn == TURN_TX && level != '0) begin
               stateNxt = (wspaceCnt == '0) ? ST_RD_CTRL : ST_WR_DATA;
            end else begin
               stateNxt = ST_RD_DATA;
               turnNxt  = TURN_RX;
            end
         end
         ST_RD_DATA: begin
            if (done) begin
               stateNxt = ST_IDLE;
               if (rdData[15]) begin
                  rxLoad   = 1'b1;
                  rxCntNxt = rxCnt + CNT_W'(1);
               end
               if (!rdData[15] || (rxCnt + CNT_W'(1)) == CNT_W'(RX_BURST)) begin
                  turnNxt  = TURN_TX;
                  rxCntNxt = '0;
               end
            end
         end
         ST_RD_CTRL: begin
            if (done) begin
               stateNxt     = ST_IDLE;
               wspaceCntNxt = rdData[31:16];
               // no host space: hand the port back to RX rather than re-polling
               if (rdData[31:16] == '0) turnNxt = TURN_RX;
            end
         end
         ST_WR_DATA: begin
            if (done) begin
               stateNxt     = ST_IDLE;
               pop          = 1'b1;
               wspaceCntNxt = wspaceCnt - WS_W'(1);
               txCntNxt     = txCnt + CNT_W'(1);
               if ((txCnt + CNT_W'(1)) == CNT_W'(TX_BURST) ||
                   (level + LW'(push)) == LW'(1) ||
                   wspaceCnt == WS_W'(1)) begin
                  turnNxt  = TURN_RX;
                  txCntNxt = '0;
               end
            end
         end
         default: stateNxt = ST_IDLE;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state                  <= ST_IDLE;
         turn                   <= TURN_RX;
         rxCnt                  <= '0;
         txCnt                  <= '0;
         wspaceCnt              <= '0;
         wrPtr                  <= '0;
         rdPtr                  <= '0;
         level                  <= '0;
         bus.oJTAG_SLAVE_ADDR   <= 1'b0;
         bus.oJTAG_SLAVE_RDREQ  <= 1'b0;
         bus.oJTAG_SLAVE_WRREQ  <= 1'b0;
         bus.oJTAG_SLAVE_WRDATA <= '0;
         bus.oRX_DATA           <= '0;
         bus.oRX_VALID          <= 1'b0;
         bus.oTX_READY          <= 1'b0;
         bus.oTX_EMPTY          <= 1'b1;
      end else begin
         state     <= stateNxt;
         turn      <= turnNxt;
         rxCnt     <= rxCntNxt;
         txCnt     <= txCntNxt;
         wspaceCnt <= wspaceCntNxt;
         level     <= levelNxt;
         if (push) wrPtr <= wrPtr + TX_FIFO_AW'(1);
         if (pop)  rdPtr <= rdPtr + TX_FIFO_AW'(1);
         // request decoded from the next state so it is stable for the whole access
         bus.oJTAG_SLAVE_ADDR   <= (stateNxt == ST_RD_CTRL);
         bus.oJTAG_SLAVE_RDREQ  <= (stateNxt == ST_RD_DATA) || (stateNxt == ST_RD_CTRL);
         bus.oJTAG_SLAVE_WRREQ  <= (stateNxt == ST_WR_DATA);
         bus.oJTAG_SLAVE_WRDATA <= (stateNxt == ST_WR_DATA) ? {24'd0, fifoMem[rdPtr]} : 32'd0;
         if (rxLoad) bus.oRX_DATA <= rdData[7:0];
         bus.oRX_VALID <= rxLoad;
         bus.oTX_READY <= readyNxt;
         bus.oTX_EMPTY <= (levelNxt == '0);
      end
   end

   // TX FIFO storage
   always_ff @(posedge iCLK) begin
      if (push) fifoMem[wrPtr] <= pushData;
   end
endmodule
